// File: rtl/dmux8way16_loader_pkg.sv
// Shared types and constants for the 8-way word loader.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package dmux8way16_loader_pkg;

    // Fixed bank geometry: eight ways addressed by a 3-bit pointer.
    localparam int NUM_WAYS = 8;
    localparam int PTR_W    = 3;

    // Every way written once in the current frame.
    localparam logic [NUM_WAYS-1:0] ALL_LOADED = 8'hFF;

    // FILL accepts words; HOLD freezes the bank for the downstream reader.
    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_e;

    // Control state of the loader, kept as one bundle so that the next-state
    // logic can start from the current value and override single fields.
    typedef struct packed {
        state_e                state;
        logic [PTR_W-1:0]      wr_ptr;
        logic [NUM_WAYS-1:0]   loaded;
        logic                  frame_done;
    } ctl_t;

    // Value the control bundle takes on reset.
    localparam ctl_t CTL_RESET = '{
        state:      FILL,
        wr_ptr:     '0,
        loaded:     '0,
        frame_done: 1'b0
    };

    // Sequential pointer advance; the 3-bit width makes way 7 wrap to way 0.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
        return ptr + PTR_W'(1);
    endfunction

endpackage : dmux8way16_loader_pkg

// File: rtl/dmux8way16_loader_dmux8way.sv
// 1-of-8 demux decoder: 3-bit select plus enable to a one-hot load strobe.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the strobe is all zeros whenever the enable is low.
module dmux8way16_loader_dmux8way
    import dmux8way16_loader_pkg::*;
(
    input  logic [PTR_W-1:0]    sel,
    input  logic                en,
    output logic [NUM_WAYS-1:0] strobe
);

    // Raise exactly one strobe bit for the selected way, only when enabled.
    always_comb begin
        strobe = '0;
        if (en) begin
            strobe[sel] = 1'b1;
        end
    end

endmodule : dmux8way16_loader_dmux8way

// File: rtl/dmux8way16_loader.sv
// Steers a valid/ready word stream into eight holding registers a..h, sequentially or by address.
// Latency: an accepted word is visible on its way output one cycle after the accept edge.
// Backpressure: in_ready drops during reset, while clear is high, and for the whole HOLD state.
module dmux8way16_loader
    import dmux8way16_loader_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             auto_inc,
    input  logic [2:0]       addr,
    input  logic             clear,
    input  logic             frame_ack,
    output logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] c,
    output logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] e,
    output logic [WIDTH-1:0] f,
    output logic [WIDTH-1:0] g,
    output logic [WIDTH-1:0] h,
    output logic [2:0]       wr_ptr,
    output logic [7:0]       loaded,
    output logic             frame_done
);

    ctl_t                ctl_q;
    ctl_t                ctl_d;
    logic [WIDTH-1:0]    way_q [NUM_WAYS];
    logic                accept;
    logic [PTR_W-1:0]    target;
    logic [NUM_WAYS-1:0] load_stb;
    logic [NUM_WAYS-1:0] loaded_set;

    // Ready depends only on state, clear and reset so that it never waits on
    // in_valid; clear and reset take priority over any incoming word.
    assign in_ready = (ctl_q.state == FILL) && !clear && !reset;
    assign accept   = in_valid && in_ready;

    // Sequential writes follow the pointer; addressed writes use addr as given
    // in the accept cycle.
    assign target = auto_inc ? ctl_q.wr_ptr : addr;

    dmux8way16_loader_dmux8way u_dmux (
        .sel    (target),
        .en     (accept),
        .strobe (load_stb)
    );

    // Loaded set including the word accepted this cycle (rewrites are idempotent).
    assign loaded_set = ctl_q.loaded | load_stb;

    // Next-state and control update: FILL collects words until every way is
    // loaded, HOLD waits for the reader's acknowledge; clear overrides both.
    always_comb begin
        ctl_d            = ctl_q;
        ctl_d.frame_done = 1'b0;
        case (ctl_q.state)
            FILL: begin
                if (accept) begin
                    ctl_d.loaded = loaded_set;
                    if (auto_inc) begin
                        ctl_d.wr_ptr = ptr_inc(ctl_q.wr_ptr);
                    end
                    if (loaded_set == ALL_LOADED) begin
                        ctl_d.state      = HOLD;
                        ctl_d.frame_done = 1'b1;
                    end
                end
            end
            HOLD: begin
                if (frame_ack) begin
                    ctl_d.state  = FILL;
                    ctl_d.loaded = '0;
                    ctl_d.wr_ptr = '0;
                end
            end
            default: begin
                ctl_d = CTL_RESET;
            end
        endcase
        if (clear) begin
            ctl_d.state      = FILL;
            ctl_d.loaded     = '0;
            ctl_d.wr_ptr     = '0;
            ctl_d.frame_done = 1'b0;
        end
    end

    // Control state register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            ctl_q <= CTL_RESET;
        end else begin
            ctl_q <= ctl_d;
        end
    end

    // Holding registers: each way loads only on its decoder strobe, so the
    // bank stays frozen in HOLD and keeps its contents across clear/ack.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_WAYS; i++) begin
            if (reset) begin
                way_q[i] <= '0;
            end else if (load_stb[i]) begin
                way_q[i] <= in_data;
            end
        end
    end

    assign a = way_q[0];
    assign b = way_q[1];
    assign c = way_q[2];
    assign d = way_q[3];
    assign e = way_q[4];
    assign f = way_q[5];
    assign g = way_q[6];
    assign h = way_q[7];

    assign wr_ptr     = ctl_q.wr_ptr;
    assign loaded     = ctl_q.loaded;
    assign frame_done = ctl_q.frame_done;

endmodule : dmux8way16_loader
